// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD  = 2;
  localparam int NREAD_MAX  = 4;

  typedef logic [DEF_ADDR_W-1:0] regIdx_t;

  function automatic bit nreadLegal(int n);
    return (n >= 1) && (n <= NREAD_MAX);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on write-back.
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clock,
  input  logic                    Reset,
  input  logic                    Issue,
  input  logic [ADDR_W-1:0]       IssueAddr,
  input  logic                    RegWrite,
  input  logic [ADDR_W-1:0]       WriteAddr,
  input  logic [NREAD*ADDR_W-1:0] ReadAddr,
  output logic [NREAD-1:0]        ReadBusy,
  output logic                    AnyBusy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy, busyNext;
  logic             issueOk;

  assign issueOk = Issue && !((ZERO_REG != 0) && (IssueAddr == '0));

  // Clear on write-back first, then set on issue so a new producer wins.
  always_comb begin
    busyNext = busy;
    if (RegWrite) busyNext[WriteAddr] = 1'b0;
    if (issueOk)  busyNext[IssueAddr] = 1'b1;
  end

  // Busy vector; reset clears it asynchronously.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) busy <= '0;
    else        busy <= busyNext;
  end

  // A same-cycle write-back to the read address resolves the hazard.
  for (genvar k = 0; k < NREAD; k++) begin : gRdBusy
    logic [ADDR_W-1:0] ra;
    assign ra          = ReadAddr[k*ADDR_W +: ADDR_W];
    assign ReadBusy[k] = busy[ra] & ~(RegWrite && (WriteAddr == ra));
  end

  assign AnyBusy = |busy;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1
) (
  input  logic                    clock,
  input  logic                    Reset,
  input  logic [NREAD*ADDR_W-1:0] ReadAddr,
  output logic [NREAD*DATA_W-1:0] ReadData,
  output logic [NREAD-1:0]        ReadBusy,
  input  logic                    RegWrite,
  input  logic [ADDR_W-1:0]       WriteAddr,
  input  logic [DATA_W-1:0]       WriteData,
  input  logic                    Issue,
  input  logic [ADDR_W-1:0]       IssueAddr,
  output logic                    AnyBusy
);
  localparam int DEPTH = 1 << ADDR_W;

  if (!nreadLegal(NREAD)) begin : gBadNread
    $error("regfile_mp: NREAD must be in 1..4");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wrOk;

  assign wrOk = RegWrite && !((ZERO_REG != 0) && (WriteAddr == '0));

  // Storage; reset wipes every register so no partial write survives.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wrOk) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  // Combinational read ports: forced 0 in reset, zero register, write-first bypass.
  for (genvar k = 0; k < NREAD; k++) begin : gRd
    logic [ADDR_W-1:0] ra;
    logic              zeroHit, bypass;
    assign ra      = ReadAddr[k*ADDR_W +: ADDR_W];
    assign zeroHit = (ZERO_REG != 0) && (ra == '0);
    assign bypass  = RegWrite && (WriteAddr == ra);
    assign ReadData[k*DATA_W +: DATA_W] = !Reset  ? '0 :
                                          zeroHit ? '0 :
                                          bypass  ? WriteData : mem[ra];
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NREAD   (NREAD),
    .ZERO_REG(ZERO_REG)
  ) uScoreboard (
    .clock    (clock),
    .Reset    (Reset),
    .Issue    (Issue),
    .IssueAddr(IssueAddr),
    .RegWrite (RegWrite),
    .WriteAddr(WriteAddr),
    .ReadAddr (ReadAddr),
    .ReadBusy (ReadBusy),
    .AnyBusy  (AnyBusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (4 read ports) with a behavioural model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic           clock = 1'b0;
  logic           Reset;
  logic [NR*AW-1:0] ReadAddr;
  logic [NR*DW-1:0] ReadData;
  logic [NR-1:0]  ReadBusy;
  logic           RegWrite;
  logic [AW-1:0]  WriteAddr;
  logic [DW-1:0]  WriteData;
  logic           Issue;
  logic [AW-1:0]  IssueAddr;
  logic           AnyBusy;

  logic [AW-1:0]  ra [NR];
  assign ReadAddr = {ra[3], ra[2], ra[1], ra[0]};

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clock(clock), .Reset(Reset), .ReadAddr(ReadAddr), .ReadData(ReadData),
    .ReadBusy(ReadBusy), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .Issue(Issue), .IssueAddr(IssueAddr), .AnyBusy(AnyBusy)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nErrors = 0;
  bit chkEn   = 1'b0;

  // Behavioural model: register contents and busy flags as plain arrays.
  logic [DW-1:0] mdl     [32];
  bit            mdlBusy [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
    if (!Reset || a == 0) return '0;
    if (RegWrite && WriteAddr == a) return WriteData;
    return mdl[a];
  endfunction

  function automatic logic expBusy(input logic [AW-1:0] a);
    if (!Reset) return 1'b0;
    return mdlBusy[a] && !(RegWrite && WriteAddr == a);
  endfunction

  function automatic logic expAny();
    for (int i = 0; i < 32; i++) if (mdlBusy[i]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin mdl[i] = '0; mdlBusy[i] = 1'b0; end
  end

  always @(negedge Reset) begin
    for (int i = 0; i < 32; i++) begin mdl[i] = '0; mdlBusy[i] = 1'b0; end
  end

  always @(posedge clock) begin
    if (Reset === 1'b1) begin
      if (RegWrite) begin
        if (WriteAddr != 0) mdl[WriteAddr] = WriteData;
        mdlBusy[WriteAddr] = 1'b0;
      end
      if (Issue && IssueAddr != 0) mdlBusy[IssueAddr] = 1'b1;
    end
  end

  // Compare process: every falling edge, all ports against the model.
  always @(negedge clock) begin
    if (chkEn) begin
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("cmpData%0d", k), 64'(ReadData[k*DW +: DW]), 64'(expRead(ra[k])));
        chk($sformatf("cmpBusy%0d", k), 64'(ReadBusy[k]), 64'(expBusy(ra[k])));
      end
      chk("cmpAny", 64'(AnyBusy), 64'(expAny()));
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic setW(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    RegWrite = we; WriteAddr = a; WriteData = d;
  endtask

  task automatic setI(input logic is, input logic [AW-1:0] a);
    Issue = is; IssueAddr = a;
  endtask

  function automatic logic [AW-1:0] rndAddr();
    return $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
  endfunction

  initial begin
    Reset = 1'b0;
    setW(0, 0, 0); setI(0, 0);
    for (int k = 0; k < NR; k++) ra[k] = '0;
    ra[1] = 5;
    chkEn = 1'b1;
    #3;
    chk("resetData1", 64'(ReadData[1*DW +: DW]), 64'h0);
    chk("resetAny", 64'(AnyBusy), 64'h0);
    step(); step();
    Reset = 1'b1;

    // Write then read back on two ports.
    step(); setW(1, 5, 32'hDEADBEEF);
    step(); setW(0, 0, 0); ra[0] = 5; ra[1] = 5;
    #2;
    chk("r5port0", 64'(ReadData[0*DW +: DW]), 64'hDEADBEEF);
    chk("r5port1", 64'(ReadData[1*DW +: DW]), 64'hDEADBEEF);

    // Same-cycle bypass.
    step(); setW(1, 7, 32'h12345678); ra[0] = 7;
    #2;
    chk("bypassR7", 64'(ReadData[0*DW +: DW]), 64'h12345678);

    // Zero register ignores writes and issues.
    step(); setW(1, 0, 32'hFFFFFFFF); setI(1, 0); ra[0] = 0;
    #2;
    chk("zeroBypass", 64'(ReadData[0*DW +: DW]), 64'h0);
    step(); setW(0, 0, 0); setI(0, 0);
    #2;
    chk("zeroData", 64'(ReadData[0*DW +: DW]), 64'h0);
    chk("zeroBusy", 64'(ReadBusy[0]), 64'h0);
    chk("zeroAny", 64'(AnyBusy), 64'h0);

    // Scoreboard set / same-cycle issue+write / clear.
    setI(1, 3);
    step(); setI(0, 0); ra[0] = 3;
    #2;
    chk("r3Busy", 64'(ReadBusy[0]), 64'h1);
    chk("r3Any", 64'(AnyBusy), 64'h1);
    step(); setW(1, 3, 32'h33); setI(1, 3);
    #2;
    chk("r3BusyResolved", 64'(ReadBusy[0]), 64'h0);
    step(); setW(0, 0, 0); setI(0, 0);
    #2;
    chk("r3BusyStays", 64'(ReadBusy[0]), 64'h1);
    chk("r3DataWritten", 64'(ReadData[0*DW +: DW]), 64'h33);
    setW(1, 3, 32'h34);
    step(); setW(0, 0, 0);
    #2;
    chk("r3BusyCleared", 64'(ReadBusy[0]), 64'h0);
    chk("r3AnyCleared", 64'(AnyBusy), 64'h0);

    // Four independent ports.
    setW(1, 2, 32'h22);  step();
    setW(1, 9, 32'h99);  step();
    setW(1, 31, 32'h31); step();
    setW(0, 0, 0); ra[0] = 2; ra[1] = 2; ra[2] = 9; ra[3] = 31;
    #2;
    chk("p0r2", 64'(ReadData[0*DW +: DW]), 64'h22);
    chk("p1r2", 64'(ReadData[1*DW +: DW]), 64'h22);
    chk("p2r9", 64'(ReadData[2*DW +: DW]), 64'h99);
    chk("p3r31", 64'(ReadData[3*DW +: DW]), 64'h31);

    // Fill r1..r31 with their index, then pulse reset between edges.
    step();
    for (int i = 1; i < 32; i++) begin
      setW(1, AW'(i), DW'(i));
      setI(i == 31, 4);
      step();
    end
    setW(0, 0, 0); setI(0, 0); ra[0] = 17; ra[1] = 30; ra[2] = 4; ra[3] = 1;
    #1;
    chk("fillR17", 64'(ReadData[0*DW +: DW]), 64'd17);
    chk("fillAny", 64'(AnyBusy), 64'h1);
    Reset = 1'b0;
    #1;
    for (int k = 0; k < NR; k++)
      chk($sformatf("pulseData%0d", k), 64'(ReadData[k*DW +: DW]), 64'h0);
    chk("pulseAny", 64'(AnyBusy), 64'h0);
    Reset = 1'b1;

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      step();
      Reset = ($urandom_range(0, 99) != 0);
      setW(1'($urandom_range(0, 1)), rndAddr(), $urandom);
      setI(1'($urandom_range(0, 2) == 0), rndAddr());
      for (int k = 0; k < NR; k++) ra[k] = rndAddr();
    end
    step();
    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
